// File: rtl/cpu_pkg.sv
// Shared encodings for the single-cycle MIPS-subset core: opcodes, functs,
// the decoder-to-ALU-control class (ALUOp) and the ALU operation select.
package cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_AND = 3'd0,
        ALU_OR  = 3'd1,
        ALU_ADD = 3'd2,
        ALU_SUB = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'd0,
        ALUOP_SUB   = 2'd1,
        ALUOP_FUNCT = 2'd2,
        ALUOP_SLT   = 2'd3
    } aluop_e;

endpackage

// File: rtl/simple_single_cpu_units.sv
// Building blocks of the single-cycle core: instruction ROM, register file,
// main decoder, ALU control and ALU.
module Instr_Memory (
    input  logic [4:0]  addr,
    output logic [31:0] instr
);
    // Preloaded from outside before reset release; the core only reads it.
    logic [31:0] Instr_Mem [0:31];

    assign instr = Instr_Mem[addr];
endmodule

module Reg_File (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic        reg_write,
    output logic [31:0] rs_data,
    output logic [31:0] rt_data
);
    logic [31:0] Reg_File [0:31];

    // r0 is cleared by reset and never written, so it always reads as zero.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < 32; i++) Reg_File[i] <= '0;
        end else if (reg_write && (wr_addr != 5'd0)) begin
            Reg_File[wr_addr] <= wr_data;
        end
    end

    assign rs_data = Reg_File[rs_addr];
    assign rt_data = Reg_File[rt_addr];
endmodule

module Decoder
    import cpu_pkg::*;
(
    input  logic [5:0] op,
    output logic       reg_dst,
    output logic       alu_src,
    output logic       reg_write,
    output logic       branch,
    output aluop_e     aluop
);
    always_comb begin
        reg_dst   = 1'b0;
        alu_src   = 1'b0;
        reg_write = 1'b0;
        branch    = 1'b0;
        aluop     = ALUOP_ADD;
        case (op)
            OP_RTYPE: begin reg_dst = 1'b1; reg_write = 1'b1; aluop = ALUOP_FUNCT; end
            OP_ADDI:  begin alu_src = 1'b1; reg_write = 1'b1; end
            OP_SLTI:  begin alu_src = 1'b1; reg_write = 1'b1; aluop = ALUOP_SLT; end
            OP_BEQ:   begin branch = 1'b1; aluop = ALUOP_SUB; end
            default:  ;
        endcase
    end
endmodule

module ALU_Ctrl
    import cpu_pkg::*;
(
    input  aluop_e     aluop,
    input  logic [5:0] funct,
    output alu_op_e    alu_op,
    output logic       funct_ok
);
    // funct_ok drops for an unrecognised R-type funct so the write is suppressed.
    always_comb begin
        alu_op   = ALU_ADD;
        funct_ok = 1'b1;
        case (aluop)
            ALUOP_ADD: alu_op = ALU_ADD;
            ALUOP_SUB: alu_op = ALU_SUB;
            ALUOP_SLT: alu_op = ALU_SLT;
            default: begin
                case (funct)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_SLT:  alu_op = ALU_SLT;
                    default: funct_ok = 1'b0;
                endcase
            end
        endcase
    end
endmodule

module ALU
    import cpu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_op_e     op,
    output logic [31:0] result,
    output logic        zero
);
    always_comb begin
        result = '0;
        case (op)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_SLT: result = {31'd0, $signed(a) < $signed(b)};
            default: result = '0;
        endcase
    end

    assign zero = (result == 32'd0);
endmodule

// File: rtl/simple_single_cpu.sv
// Single-cycle MIPS-subset core: fetch, decode, execute and write back all
// complete at one rising edge. Program lives in IM, results in RF.
module simple_single_cpu
    import cpu_pkg::*;
(
    input logic clk_i,
    input logic rst_i
);
    // Only 32 instruction words exist, so the byte PC is kept modulo 128.
    logic [6:0]  pc_reg, pc_next, pc_plus4, pc_branch;
    logic [31:0] instr, rs_data, rt_data, sext_imm, alu_b, alu_result;
    logic [4:0]  wr_addr;
    logic        reg_dst, alu_src, reg_write, branch, funct_ok, zero, rf_write;
    aluop_e      aluop;
    alu_op_e     alu_op;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) pc_reg <= '0;
        else        pc_reg <= pc_next;
    end

    Instr_Memory IM (.addr(pc_reg[6:2]), .instr(instr));

    Decoder u_decoder (
        .op(instr[31:26]), .reg_dst(reg_dst), .alu_src(alu_src),
        .reg_write(reg_write), .branch(branch), .aluop(aluop)
    );

    ALU_Ctrl u_alu_ctrl (.aluop(aluop), .funct(instr[5:0]), .alu_op(alu_op), .funct_ok(funct_ok));

    assign sext_imm = {{16{instr[15]}}, instr[15:0]};
    assign alu_b    = alu_src ? sext_imm : rt_data;
    assign wr_addr  = reg_dst ? instr[15:11] : instr[20:16];
    assign rf_write = reg_write & funct_ok;

    Reg_File RF (
        .clk_i(clk_i), .rst_i(rst_i),
        .rs_addr(instr[25:21]), .rt_addr(instr[20:16]),
        .wr_addr(wr_addr), .wr_data(alu_result), .reg_write(rf_write),
        .rs_data(rs_data), .rt_data(rt_data)
    );

    ALU u_alu (.a(rs_data), .b(alu_b), .op(alu_op), .result(alu_result), .zero(zero));

    // Branch offset only matters modulo 128 bytes, so its low word bits suffice.
    assign pc_plus4  = pc_reg + 7'd4;
    assign pc_branch = pc_plus4 + {sext_imm[4:0], 2'b00};
    assign pc_next   = (branch && zero) ? pc_branch : pc_plus4;

endmodule

// File: tb/tb_simple_single_cpu.sv
// Bench for simple_single_cpu: directed and random programs checked against
// an instruction-level reference model of the MIPS subset.
module tb_simple_single_cpu;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    int   total = 0;
    int   bad   = 0;

    simple_single_cpu dut (.clk_i(clk_i), .rst_i(rst_i));

    always #5 clk_i = ~clk_i;

    localparam logic [31:0] HALT = 32'h1000FFFF;   // beq r0,r0,-1

    logic [31:0] prog [0:31];
    logic [31:0] mreg [0:31];
    int          mpc;

    function automatic logic [31:0] r_ins(int rs, int rt, int rd, int fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
    endfunction

    function automatic logic [31:0] i_ins(int op, int rs, int rt, int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 32; i++) prog[i] = HALT;
    endtask

    // Architectural step: one instruction executed from the rules of the ISA.
    task automatic model_step();
        logic [31:0] w, a, b, res;
        int op, rs, rt, rd, fn, imm, dest, nxt;
        bit wr;
        w   = prog[mpc / 4];
        op  = int'(w[31:26]);
        rs  = int'(w[25:21]);
        rt  = int'(w[20:16]);
        rd  = int'(w[15:11]);
        fn  = int'(w[5:0]);
        imm = int'($signed(w[15:0]));
        a   = mreg[rs];
        b   = mreg[rt];
        wr  = 1'b0;
        dest = 0;
        res = '0;
        nxt = (mpc + 4) % 128;
        if (op == 0) begin
            dest = rd;
            wr   = 1'b1;
            case (fn)
                32'h20:  res = a + b;
                32'h22:  res = a - b;
                32'h24:  res = a & b;
                32'h25:  res = a | b;
                32'h2A:  res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                default: wr = 1'b0;
            endcase
        end else if (op == 8) begin
            dest = rt; wr = 1'b1; res = a + 32'(imm);
        end else if (op == 10) begin
            dest = rt; wr = 1'b1; res = ($signed(a) < imm) ? 32'd1 : 32'd0;
        end else if (op == 4 && a == b) begin
            nxt = ((mpc + 4 + imm * 4) % 128 + 128) % 128;
        end
        if (wr && dest != 0) mreg[dest] = res;
        mpc = nxt;
    endtask

    task automatic check_regs(string tag);
        for (int i = 0; i < 32; i++)
            check($sformatf("%s_r%0d", tag, i), dut.RF.Reg_File[i], mreg[i]);
    endtask

    // Hold reset across a falling edge, load the program, verify cleared state, release.
    task automatic reset_and_load(string tag);
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int i = 0; i < 32; i++) dut.IM.Instr_Mem[i] = prog[i];
        for (int i = 0; i < 32; i++) mreg[i] = '0;
        mpc = 0;
        @(negedge clk_i);
        check({tag, "_reset_pc"}, 32'(dut.pc_reg), 32'd0);
        check_regs({tag, "_reset"});
        rst_i = 1'b1;
    endtask

    task automatic run(string tag, int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk_i);
            #1;
            model_step();
            check($sformatf("%s_pc%0d", tag, c), 32'(dut.pc_reg), 32'(mpc));
        end
        $display("program %s: %0d cycles retired, pc=%0d", tag, n, mpc);
    endtask

    initial begin
        // AND/OR program
        clear_prog();
        prog[0] = i_ins(8, 0, 1, 12);
        prog[1] = i_ins(8, 0, 2, 10);
        prog[2] = r_ins(1, 2, 3, 6'h24);
        prog[3] = r_ins(1, 2, 4, 6'h25);
        reset_and_load("and");
        run("and", 4);
        check_regs("and");
        check("and_r3_const", dut.RF.Reg_File[3], 32'd8);
        check("and_r4_const", dut.RF.Reg_File[4], 32'd14);

        // add/sub with negative immediate
        clear_prog();
        prog[0] = i_ins(8, 0, 1, 5);
        prog[1] = i_ins(8, 0, 2, -3);
        prog[2] = r_ins(1, 2, 3, 6'h22);
        prog[3] = r_ins(1, 2, 4, 6'h20);
        reset_and_load("arith");
        run("arith", 4);
        check_regs("arith");
        check("arith_r3_const", dut.RF.Reg_File[3], 32'd8);
        check("arith_r4_const", dut.RF.Reg_File[4], 32'd2);

        // Overflow wrap: build 2^31 by doubling, then step around 0x7FFFFFFF
        clear_prog();
        prog[0] = i_ins(8, 0, 6, 16384);
        for (int i = 1; i <= 17; i++) prog[i] = r_ins(6, 6, 6, 6'h20);
        prog[18] = i_ins(8, 6, 7, -1);
        prog[19] = i_ins(8, 7, 8, 1);
        reset_and_load("ovf");
        run("ovf", 20);
        check_regs("ovf");
        check("ovf_r7_const", dut.RF.Reg_File[7], 32'h7FFFFFFF);
        check("ovf_r8_const", dut.RF.Reg_File[8], 32'h80000000);

        // slt / slti signed compares
        clear_prog();
        prog[0] = i_ins(8, 0, 1, -3);
        prog[1] = i_ins(8, 0, 2, 5);
        prog[2] = r_ins(1, 2, 3, 6'h2A);
        prog[3] = r_ins(2, 1, 4, 6'h2A);
        prog[4] = i_ins(10, 2, 5, 6);
        prog[5] = i_ins(10, 1, 6, -4);
        reset_and_load("slt");
        run("slt", 6);
        check_regs("slt");
        check("slt_r3_const", dut.RF.Reg_File[3], 32'd1);
        check("slt_r4_const", dut.RF.Reg_File[4], 32'd0);
        check("slt_r5_const", dut.RF.Reg_File[5], 32'd1);

        // beq taken/not taken, r0 write, unknown opcode and funct, self loop
        clear_prog();
        prog[0] = i_ins(8, 0, 1, 1);
        prog[1] = i_ins(4, 0, 0, 2);
        prog[2] = i_ins(8, 0, 2, 9);
        prog[3] = i_ins(8, 0, 3, 9);
        prog[4] = i_ins(4, 1, 0, 5);
        prog[5] = i_ins(8, 0, 4, 4);
        prog[6] = i_ins(8, 0, 0, 7);
        prog[7] = i_ins(6'h3F, 0, 1, 1);
        prog[8] = r_ins(1, 1, 5, 6'h3F);
        reset_and_load("beq");
        run("beq", 7);
        check("beq_pc_halt", 32'(dut.pc_reg), 32'd36);
        run("beq_hold", 3);
        check("beq_pc_hold", 32'(dut.pc_reg), 32'd36);
        check_regs("beq");
        check("beq_r2_skipped", dut.RF.Reg_File[2], 32'd0);
        check("beq_r4_const", dut.RF.Reg_File[4], 32'd4);
        check("beq_r1_unknown", dut.RF.Reg_File[1], 32'd1);

        // Asynchronous reset between clock edges
        @(posedge clk_i);
        #2;
        rst_i = 1'b0;
        #1;
        for (int i = 0; i < 32; i++) mreg[i] = '0;
        mpc = 0;
        check("async_pc", 32'(dut.pc_reg), 32'd0);
        check_regs("async");
        $display("async reset applied mid-cycle");

        // Random programs
        for (int p = 0; p < 3; p++) begin
            clear_prog();
            for (int i = 0; i < 24; i++) begin
                int k, rs, rt, rd, imm;
                k   = $urandom_range(0, 8);
                rs  = $urandom_range(0, 7);
                rt  = $urandom_range(0, 7);
                rd  = $urandom_range(0, 7);
                imm = int'($urandom_range(0, 40)) - 20;
                case (k)
                    0: prog[i] = r_ins(rs, rt, rd, 6'h20);
                    1: prog[i] = r_ins(rs, rt, rd, 6'h22);
                    2: prog[i] = r_ins(rs, rt, rd, 6'h24);
                    3: prog[i] = r_ins(rs, rt, rd, 6'h25);
                    4: prog[i] = r_ins(rs, rt, rd, 6'h2A);
                    5: prog[i] = i_ins(8, rs, rt, imm);
                    6: prog[i] = i_ins(10, rs, rt, imm);
                    7: prog[i] = i_ins(4, rs, rt, int'($urandom_range(0, 4)) - 1);
                    default: prog[i] = ($urandom_range(0, 1) == 0) ?
                                       i_ins(6'h23, rs, rt, imm) : r_ins(rs, rt, rd, 6'h27);
                endcase
            end
            reset_and_load($sformatf("rand%0d", p));
            run($sformatf("rand%0d", p), 40);
            check_regs($sformatf("rand%0d", p));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
